// File: rtl/route_sequencer_pkg.sv
// route_sequencer_pkg: shared route RAM geometry, terminator code and sequencer state encodings
package route_sequencer_pkg;

    localparam int ROUTE_ADDR_W = 4;
    localparam int ROUTE_DATA_W = 4;
    localparam logic [ROUTE_DATA_W-1:0] ROUTE_END_CODE = 4'b1111;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_OFFER   = 3'd3;
    localparam logic [2:0] S_DWELL   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/route_sequencer.sv
// route_sequencer: walks the route RAM and offers each command downstream over valid/ready
module route_sequencer
    import route_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = ROUTE_ADDR_W,
    parameter int                DATA_W     = ROUTE_DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [DATA_W-1:0] END_CODE   = ROUTE_END_CODE,
    parameter int                DWELL      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] cmd,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step
);

    localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((DWELL > 0) ? DWELL - 1 : 0);

    logic [2:0]    state, next;
    logic [CW-1:0] cnt;
    logic          hs, adv, wrap, go;
    logic [2:0]    adv_state;

    assign hs        = (state == S_OFFER) && cmd_ready;
    assign adv       = (hs && DWELL == 0) || (state == S_DWELL && cnt == '0);
    assign wrap      = &ram_addr;
    assign go        = start && (state == S_IDLE || state == S_DONE);
    assign adv_state = (wrap && !loop_en) ? S_DONE : S_FETCH;
    assign ram_we    = 1'b0;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next;
    end

    // next-state logic; abort overrides everything else
    always_comb begin
        next = state;
        if (abort) next = S_IDLE;
        else case (state)
            S_IDLE, S_DONE: next = start ? S_FETCH : state;
            S_FETCH:        next = S_CAPTURE;
            S_CAPTURE:      next = (ram_q == END_CODE) ? S_DONE : S_OFFER;
            S_OFFER:        next = hs ? ((DWELL > 0) ? S_DWELL : adv_state) : S_OFFER;
            S_DWELL:        next = (cnt == '0) ? adv_state : S_DWELL;
            default:        next = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        cmd_valid = (state == S_OFFER);
        done      = (state == S_DONE);
        busy      = !(state == S_IDLE || state == S_DONE);
    end

    // address counter, dwell counter and command/step capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr <= START_ADDR;
            cmd      <= '0;
            step     <= '0;
            cnt      <= '0;
        end else if (abort) begin
            ram_addr <= START_ADDR;
        end else begin
            if (go) ram_addr <= START_ADDR;
            if (adv) ram_addr <= wrap ? START_ADDR : ram_addr + 1'b1;
            if (state == S_CAPTURE && ram_q != END_CODE) begin
                cmd  <= ram_q;
                step <= ram_addr;
            end
            if (hs) cnt <= CNT_LOAD;
            else if (state == S_DWELL && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_route_sequencer.sv
// tb_route_sequencer: directed scenarios against a registered-address route RAM model
module tb_route_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, start, abort, loop_en, cmd_ready;
    logic [3:0] ram_addr, ram_q, cmd, step;
    logic       ram_we, cmd_valid, busy, done;
    logic [3:0] mem [16];
    logic [3:0] addr_q;
    int         total = 0;
    int         bad = 0;

    route_sequencer #(.DWELL(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .loop_en(loop_en),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .busy(busy), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    // route RAM model: address registered on the clock, data read asynchronously
    always @(posedge clk) addr_q <= ram_addr;
    assign ram_q = mem[addr_q];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!cmd_valid && n < max) begin
            tick();
            n++;
        end
        total++;
        if (cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_valid: cmd_valid=%b after %0d cycles, want 1", cmd_valid, n);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({cmd_valid, busy, done, ram_addr, cmd, step, ram_we} !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: valid/busy/done=%b%b%b addr=%h cmd=%h step=%h we=%b, want all 0",
                     cmd_valid, busy, done, ram_addr, cmd, step, ram_we);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_route();
        int n;
        cmd_ready = 1'b1;
        loop_en   = 1'b0;
        pulse_start();
        total++;
        if ({cmd_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL start_fetch: valid/busy=%b%b, want 01", cmd_valid, busy);
        end
        for (int a = 0; a < 16; a++) begin
            wait_valid(8, n);
            total++;
            if (n !== ((a == 0) ? 2 : 4)) begin
                bad++;
                $display("FAIL route_gap[%0d]: %0d cycles, want %0d", a, n, (a == 0) ? 2 : 4);
            end
            total++;
            if (cmd !== mem[a] || step !== 4'(a)) begin
                bad++;
                $display("FAIL route_cmd[%0d]: cmd=%h step=%h, want cmd=%h step=%h", a, cmd, step, mem[a], 4'(a));
            end
            tick();
        end
        tick();
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL route_dwell_end: busy/done=%b%b, want 10", busy, done);
        end
        tick();
        total++;
        if ({cmd_valid, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL route_done: valid/busy/done=%b%b%b, want 001", cmd_valid, busy, done);
        end
    endtask

    task automatic test_backpressure();
        int n;
        cmd_ready = 1'b0;
        pulse_start();
        wait_valid(8, n);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        wait_valid(8, n);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({cmd_valid, cmd, step} !== 9'b1_1010_0001) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b cmd=%h step=%h, want 1 a 1", i, cmd_valid, cmd, step);
            end
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drop: valid=%b, want 0", cmd_valid);
        end
        wait_valid(8, n);
        total++;
        if (n !== 4 || cmd !== 4'b0010 || step !== 4'd2) begin
            bad++;
            $display("FAIL bp_next: gap=%0d cmd=%h step=%h, want gap=4 cmd=2 step=2", n, cmd, step);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        cmd_ready = 1'b0;
        pulse_start();
        wait_valid(8, n);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        wait_valid(8, n);
        reset_n = 1'b0;
        #1;
        total++;
        if ({cmd_valid, busy, done, ram_addr, cmd, step} !== 15'h0) begin
            bad++;
            $display("FAIL reset_mid: valid/busy/done=%b%b%b addr=%h cmd=%h step=%h, want all 0",
                     cmd_valid, busy, done, ram_addr, cmd, step);
        end
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({cmd_valid, busy} !== 2'b00) begin
                bad++;
                $display("FAIL reset_release[%0d]: valid/busy=%b%b, want 00", i, cmd_valid, busy);
            end
        end
    endtask

    task automatic test_terminator();
        int  n;
        logic saw = 1'b0;
        mem[3]    = 4'b1111;
        cmd_ready = 1'b1;
        loop_en   = 1'b0;
        pulse_start();
        for (int a = 0; a < 3; a++) begin
            wait_valid(8, n);
            total++;
            if (cmd !== mem[a] || step !== 4'(a)) begin
                bad++;
                $display("FAIL term_cmd[%0d]: cmd=%h step=%h, want cmd=%h step=%h", a, cmd, step, mem[a], 4'(a));
            end
            tick();
        end
        for (int i = 0; i < 8 && !done; i++) begin
            saw |= cmd_valid;
            tick();
        end
        total++;
        if ({done, busy, saw} !== 3'b100) begin
            bad++;
            $display("FAIL term_done: done/busy/saw_valid=%b%b%b, want 100", done, busy, saw);
        end
        mem[3] = 4'b0100;
    endtask

    task automatic test_loop();
        int n;
        cmd_ready = 1'b1;
        loop_en   = 1'b1;
        pulse_start();
        total++;
        if ({done, busy} !== 2'b01) begin
            bad++;
            $display("FAIL loop_start: done/busy=%b%b, want 01", done, busy);
        end
        for (int a = 0; a < 16; a++) begin
            wait_valid(8, n);
            tick();
        end
        wait_valid(8, n);
        total++;
        if (n !== 4 || step !== 4'd0 || cmd !== 4'b0000 || done !== 1'b0) begin
            bad++;
            $display("FAIL loop_wrap: gap=%0d step=%h cmd=%h done=%b, want 4 0 0 0", n, step, cmd, done);
        end
        loop_en = 1'b0;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        cmd_ready = 1'b1;
        pulse_start();
        wait_valid(8, n);
        tick();
        wait_valid(8, n);
        tick();
        total++;
        if ({cmd_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL abort_pre: valid/busy=%b%b, want 01", cmd_valid, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({cmd_valid, busy, done, ram_addr, cmd} !== 11'b000_0000_1010) begin
            bad++;
            $display("FAIL abort_dwell: valid/busy/done=%b%b%b addr=%h cmd=%h, want 000 0 a",
                     cmd_valid, busy, done, ram_addr, cmd);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        total++;
        if ({cmd_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL start_abort: valid/busy=%b%b, want 00", cmd_valid, busy);
        end
    endtask

    task automatic test_start_busy();
        int n;
        cmd_ready = 1'b1;
        pulse_start();
        wait_valid(8, n);
        tick();
        pulse_start();
        wait_valid(8, n);
        total++;
        if (step !== 4'd1 || cmd !== 4'b1010) begin
            bad++;
            $display("FAIL start_busy: step=%h cmd=%h, want step=1 cmd=a", step, cmd);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        loop_en   = 1'b0;
        cmd_ready = 1'b0;
        mem = '{4'h0, 4'hA, 4'h2, 4'h4, 4'h6, 4'h8, 4'h3, 4'h5,
                4'h7, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'h1, 4'h5};
        test_reset();
        test_full_route();
        test_backpressure();
        test_reset_mid();
        test_terminator();
        test_loop();
        test_abort();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
